// File: rtl/lift_pkg.sv
// ----------------------------------------------------------------------------
// lift_pkg: shared state encoding, direction constants and call-mask helpers
// for lift_scheduler.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package lift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } lift_state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int unsigned LIFT_MAX_FLOORS = 32;

  // True when any call lies strictly beyond floor in the given direction.
  function automatic logic calls_beyond(input logic [LIFT_MAX_FLOORS-1:0] calls,
                                        input int unsigned floor,
                                        input logic up);
    logic found;
    found = 1'b0;
    for (int unsigned k = 0; k < LIFT_MAX_FLOORS; k++) begin
      if (calls[k] && (up ? (k > floor) : (k < floor))) found = 1'b1;
    end
    return found;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lift_scheduler_tick_sync.sv
// ----------------------------------------------------------------------------
// tick_sync: two-flop synchroniser for clk_1s plus rising-edge one-cycle pulse.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tick_sync (
  input  logic clk_100MHz,
  input  logic rst,
  input  logic clk_1s,
  output logic tick
);

  // [0],[1] form the synchroniser, [2] holds the previous synchronised level
  logic [2:0] r_sync;
  logic       r_tick;

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      r_sync <= '0;
      r_tick <= 1'b0;
    end else begin
      r_sync <= {r_sync[1:0], clk_1s};
      r_tick <= r_sync[1] & ~r_sync[2];
    end
  end

  assign tick = r_tick;

endmodule

`default_nettype wire

// File: rtl/lift_scheduler.sv
// ----------------------------------------------------------------------------
// lift_scheduler: SCAN lift-car sequencer stepped by a 1 s strobe; optional
// emergency-stop freeze when LIFT_ESTOP_EN is defined.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lift_scheduler
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W    = 3,
  parameter int MOVE_TICKS = 2,
  parameter int DOOR_TICKS = 3
) (
  input  logic                  clk_100MHz,
  input  logic                  rst,
  input  logic                  clk_1s,
  input  logic [NUM_FLOORS-1:0] req,
`ifdef LIFT_ESTOP_EN
  input  logic                  estop,
  output logic                  estop_active,
`endif
  output logic [NUM_FLOORS-1:0] pending,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open
);

  localparam int MAX_TICKS = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);
  localparam logic [CNT_W-1:0]   MOVE_LAST = CNT_W'(MOVE_TICKS - 1);
  localparam logic [CNT_W-1:0]   DOOR_LAST = CNT_W'(DOOR_TICKS - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

  lift_state_t               r_state, w_nxt_state;
  logic [FLOOR_W-1:0]        r_floor, w_nxt_floor, w_step_floor;
  logic                      r_dir, w_nxt_dir;
  logic [CNT_W-1:0]          r_cnt, w_nxt_cnt;
  logic [NUM_FLOORS-1:0]     r_pending, w_pend, w_clear;
  logic [NUM_FLOORS-1:0]     w_cur_onehot, w_step_onehot, w_door_mask;
  logic [LIFT_MAX_FLOORS-1:0] w_pend_ext;
  logic                      r_moving, r_door;
  logic                      w_tick, w_freeze, w_req_cur;
  logic                      w_hit_cur, w_hit_step, w_ahead_cur, w_ahead_step, w_behind_step;

  tick_sync u_tick_sync (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .clk_1s     (clk_1s),
    .tick       (w_tick)
  );

`ifdef LIFT_ESTOP_EN
  assign w_freeze = estop;
`else
  assign w_freeze = 1'b0;
`endif

  // A call for the floor whose door is open is absorbed as a door restart.
  always_comb begin
    w_cur_onehot          = '0;
    w_cur_onehot[r_floor] = 1'b1;
    w_door_mask           = (r_state == ST_DOOR) ? w_cur_onehot : '0;
    w_pend                = r_pending | (req & ~w_door_mask);
    w_req_cur             = (r_state == ST_DOOR) && req[r_floor];

    if (r_dir == DIR_UP) w_step_floor = (r_floor == TOP_FLOOR) ? r_floor : r_floor + 1'b1;
    else                 w_step_floor = (r_floor == '0) ? r_floor : r_floor - 1'b1;
    w_step_onehot               = '0;
    w_step_onehot[w_step_floor] = 1'b1;

    w_pend_ext                   = '0;
    w_pend_ext[NUM_FLOORS-1:0]   = w_pend;
    w_hit_cur     = w_pend[r_floor];
    w_hit_step    = w_pend[w_step_floor];
    w_ahead_cur   = calls_beyond(w_pend_ext, 32'(r_floor), r_dir);
    w_ahead_step  = calls_beyond(w_pend_ext, 32'(w_step_floor), r_dir);
    w_behind_step = calls_beyond(w_pend_ext, 32'(w_step_floor), ~r_dir);
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_floor = r_floor;
    w_nxt_dir   = r_dir;
    w_nxt_cnt   = r_cnt;
    w_clear     = '0;
    if (!w_freeze) begin
      unique case (r_state)
        ST_IDLE: begin
          if (|w_pend) begin
            w_nxt_cnt = '0;
            if (w_hit_cur) begin
              w_nxt_state = ST_DOOR;
              w_clear     = w_cur_onehot;
            end else begin
              w_nxt_state = ST_MOVE;
              if (!w_ahead_cur) w_nxt_dir = ~r_dir;
            end
          end
        end
        ST_MOVE: begin
          if (w_tick) begin
            if (r_cnt == MOVE_LAST) begin
              w_nxt_floor = w_step_floor;
              w_nxt_cnt   = '0;
              if (w_hit_step) begin
                w_nxt_state = ST_DOOR;
                w_clear     = w_step_onehot;
              end else if (!w_ahead_step) begin
                if (w_behind_step) w_nxt_dir   = ~r_dir;
                else               w_nxt_state = ST_IDLE;
              end
            end else begin
              w_nxt_cnt = r_cnt + 1'b1;
            end
          end
        end
        ST_DOOR: begin
          if (w_req_cur) begin
            w_nxt_cnt = '0;
          end else if (w_tick) begin
            if (r_cnt == DOOR_LAST) begin
              w_nxt_state = ST_IDLE;
              w_nxt_cnt   = '0;
            end else begin
              w_nxt_cnt = r_cnt + 1'b1;
            end
          end
        end
        default: w_nxt_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_floor   <= '0;
      r_dir     <= DIR_UP;
      r_cnt     <= '0;
      r_pending <= '0;
      r_moving  <= 1'b0;
      r_door    <= 1'b0;
`ifdef LIFT_ESTOP_EN
      estop_active <= 1'b0;
`endif
    end else begin
      r_state   <= w_nxt_state;
      r_floor   <= w_nxt_floor;
      r_dir     <= w_nxt_dir;
      r_cnt     <= w_nxt_cnt;
      r_pending <= w_pend & ~w_clear;
      r_moving  <= (w_nxt_state == ST_MOVE) && !w_freeze;
      r_door    <= (w_nxt_state == ST_DOOR);
`ifdef LIFT_ESTOP_EN
      estop_active <= estop;
`endif
    end
  end

  assign pending       = r_pending;
  assign current_floor = r_floor;
  assign dir_up        = r_dir;
  assign moving        = r_moving;
  assign door_open     = r_door;

endmodule

`default_nettype wire
